// File: rtl/qos_wrr_stream_arbiter.sv
// Packet-aware weighted round-robin arbiter: grants one valid/ready stream at a time,
// holds the grant until the last beat, and lets a stream keep the grant for up to
// its QoS weight in consecutive packets.
module qos_wrr_stream_arbiter #(
  parameter int unsigned STREAM_COUNT = 4,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned QOS_W        = 4,
  localparam int unsigned ID_W        = $clog2(STREAM_COUNT)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           en,
  input  logic [STREAM_COUNT-1:0]        s_valid,
  output logic [STREAM_COUNT-1:0]        s_ready,
  input  logic [STREAM_COUNT*DATA_W-1:0] s_data,
  input  logic [STREAM_COUNT-1:0]        s_last,
  input  logic [STREAM_COUNT*QOS_W-1:0]  s_qos,
  output logic                           m_valid,
  input  logic                           m_ready,
  output logic [DATA_W-1:0]              m_data,
  output logic                           m_last,
  output logic [ID_W-1:0]                m_id
);

  typedef enum logic [0:0] {StIdle, StLocked} state_e;

  state_e            state_q;
  logic [ID_W-1:0]   sel_q;
  logic [QOS_W-1:0]  credit_q;

  logic [DATA_W-1:0] data_arr [STREAM_COUNT];
  logic [QOS_W-1:0]  qos_arr  [STREAM_COUNT];

  for (genvar i = 0; i < STREAM_COUNT; i++) begin : g_unpack
    assign data_arr[i] = s_data[i*DATA_W +: DATA_W];
    assign qos_arr[i]  = s_qos[i*QOS_W +: QOS_W];
  end

  logic              cont;
  logic              found;
  logic [ID_W-1:0]   idx;
  logic [ID_W-1:0]   win;
  logic [QOS_W-1:0]  win_qos;
  logic [QOS_W-1:0]  reload;

  // Continuation keeps the current stream while credit remains; otherwise search
  // round-robin starting after the previous winner, with the previous winner last.
  always_comb begin
    cont  = (credit_q != '0) && s_valid[sel_q];
    win   = sel_q;
    found = 1'b0;
    idx   = '0;
    if (!cont) begin
      for (int unsigned k = 1; k <= STREAM_COUNT; k++) begin
        idx = ID_W'((32'(sel_q) + k) % STREAM_COUNT);
        if (!found && s_valid[idx]) begin
          win   = idx;
          found = 1'b1;
        end
      end
    end
    win_qos = qos_arr[win];
    // A weight of zero behaves as one packet per burst.
    reload  = (win_qos == '0) ? '0 : win_qos - QOS_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      sel_q    <= ID_W'(STREAM_COUNT - 1);
      credit_q <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (en && |s_valid) begin
            sel_q    <= win;
            credit_q <= cont ? credit_q - QOS_W'(1) : reload;
            state_q  <= StLocked;
          end
        end
        StLocked: begin
          if (m_valid && m_ready && m_last) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Unbuffered pass-through of the locked stream.
  always_comb begin
    m_valid = 1'b0;
    m_data  = '0;
    m_last  = 1'b0;
    s_ready = '0;
    if (state_q == StLocked) begin
      m_valid        = s_valid[sel_q];
      m_data         = data_arr[sel_q];
      m_last         = s_last[sel_q];
      s_ready[sel_q] = m_ready;
    end
  end

  assign m_id = sel_q;

endmodule

// File: tb/tb_qos_wrr_stream_arbiter.sv
// Randomised bench for qos_wrr_stream_arbiter: packet sources, a burst-level arbitration
// model and a scoreboard of expected output beats checked by an independent monitor.
module tb_qos_wrr_stream_arbiter;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int QW = 4;

  logic            clk = 1'b0;
  logic            rst, en, m_ready, m_valid, m_last;
  logic [N-1:0]    s_valid, s_ready, s_last;
  logic [N*DW-1:0] s_data;
  logic [N*QW-1:0] s_qos;
  logic [DW-1:0]   m_data;
  logic [1:0]      m_id;

  always #5 clk = ~clk;

  qos_wrr_stream_arbiter #(
    .STREAM_COUNT(N),
    .DATA_W      (DW),
    .QOS_W       (QW)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .s_valid(s_valid),
    .s_ready(s_ready),
    .s_data (s_data),
    .s_last (s_last),
    .s_qos  (s_qos),
    .m_valid(m_valid),
    .m_ready(m_ready),
    .m_data (m_data),
    .m_last (m_last),
    .m_id   (m_id)
  );

  typedef struct packed {
    logic [1:0]  id;
    logic        last;
    logic [31:0] data;
  } beat_t;

  beat_t sb[$];
  int    n_checks = 0;
  int    n_fail   = 0;
  int    n_beats  = 0;

  // Expected outputs for the current cycle, published by the driver.
  logic         exp_known = 1'b0;
  logic         exp_mvalid, exp_mlast;
  logic [N-1:0] exp_sready;
  logic [1:0]   exp_mid;
  logic [31:0]  exp_mdata;

  // Sources: current beat per stream and beats left in the current packet.
  logic        vld   [N];
  logic [31:0] cdata [N];
  int          rem   [N];

  // Reference model: lock flag, granted stream, packets left in the burst.
  bit locked = 1'b0;
  int sel    = N - 1;
  int credit = 0;
  bit known  = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  task automatic run(input int cycles, input int pval, input int maxlen, input int prdy,
                     input int pen, input int prst, input int qmode);
    int q [N];
    bit any, hs, hs_last, found;
    int hs_s, w, j;
    for (int c = 0; c < cycles; c++) begin
      @(posedge clk);
      #1;
      rst     = ($urandom_range(0, 999) < prst);
      en      = ($urandom_range(0, 99) < pen);
      m_ready = ($urandom_range(0, 99) < prdy);
      any     = 1'b0;
      for (int i = 0; i < N; i++) begin
        case (qmode)
          0:       q[i] = 1;
          1:       q[i] = (i == 0) ? 3 : 1;
          2:       q[i] = $urandom_range(0, 15);
          default: q[i] = $urandom_range(0, 3);
        endcase
        if (!vld[i]) vld[i] = ($urandom_range(0, 99) < pval);
        any                    = any | vld[i];
        s_valid[i]             = vld[i];
        s_last[i]              = (rem[i] == 1);
        s_data[i*DW +: DW]     = cdata[i];
        s_qos[i*QW +: QW]      = QW'(q[i]);
      end

      exp_known  = known;
      exp_mid    = 2'(sel);
      exp_mvalid = locked && vld[sel];
      exp_sready = '0;
      if (locked) exp_sready[sel] = m_ready;
      exp_mdata  = locked ? cdata[sel] : 32'h0;
      exp_mlast  = locked && (rem[sel] == 1);

      hs      = locked && vld[sel] && m_ready;
      hs_s    = sel;
      hs_last = (rem[sel] == 1);
      if (hs && known) sb.push_back({2'(sel), hs_last, cdata[sel]});

      if (rst) begin
        locked = 1'b0;
        sel    = N - 1;
        credit = 0;
        known  = 1'b1;
      end else if (locked) begin
        if (hs && hs_last) locked = 1'b0;
      end else if (en && any) begin
        if (credit > 0 && vld[sel]) begin
          credit--;
        end else begin
          found = 1'b0;
          w     = sel;
          for (int k = 1; k <= N; k++) begin
            j = (sel + k) % N;
            if (!found && vld[j]) begin
              w     = j;
              found = 1'b1;
            end
          end
          sel    = w;
          credit = ((q[w] == 0) ? 1 : q[w]) - 1;
        end
        locked = 1'b1;
      end

      if (hs) begin
        vld[hs_s]   = 1'b0;
        cdata[hs_s] = $urandom;
        rem[hs_s]--;
        if (rem[hs_s] == 0) rem[hs_s] = $urandom_range(1, maxlen);
      end
    end
  endtask

  // Monitor: per-cycle output checks plus scoreboard pop on every output handshake.
  initial begin
    beat_t b;
    forever begin
      @(negedge clk);
      if (exp_known) begin
        check("m_valid", 64'(m_valid), 64'(exp_mvalid));
        check("s_ready", 64'(s_ready), 64'(exp_sready));
        check("m_id",    64'(m_id),    64'(exp_mid));
        check("m_data",  64'(m_data),  64'(exp_mdata));
        check("m_last",  64'(m_last),  64'(exp_mlast));
        if (m_valid && m_ready) begin
          if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL beat: got unexpected beat id=%0d data=%0h, required none (t=%0t)",
                     m_id, m_data, $time);
          end else begin
            b = sb.pop_front();
            n_beats++;
            check("beat", 64'({m_id, m_last, m_data}), 64'(b));
          end
        end
      end
    end
  end

  initial begin
    rst     = 1'b1;
    en      = 1'b0;
    m_ready = 1'b0;
    s_valid = '0;
    s_last  = '0;
    s_data  = '0;
    s_qos   = '0;
    for (int i = 0; i < N; i++) begin
      vld[i]   = 1'b0;
      cdata[i] = $urandom;
      rem[i]   = 1;
    end
    run(3,    100, 1, 100, 100, 1000, 0);
    run(200,  100, 1, 100, 100, 0,    0);
    run(200,  100, 1, 100, 100, 0,    1);
    run(2000, 60,  4, 50,  90,  5,    2);
    run(2000, 30,  6, 70,  70,  10,   3);
    run(2000, 90,  3, 80,  50,  0,    2);
    @(negedge clk);
    #1;
    check("scoreboard_drain", 64'(sb.size()), 64'(0));
    check("beats_seen", 64'(n_beats > 500), 64'(1));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
